// File: rtl/maze_episode_controller.sv
// Episode sequencer for a tabular Q-learning agent walking a square maze.
// Each step reads the current Q row, lets an external selector choose an
// action, computes the move and its reward, and hands the transition to an
// external updater through a valid/ready handshake. Episodes repeat with a
// linearly shrinking exploration threshold until the run is complete.
module maze_episode_controller #(
  parameter int GRID_W       = 4,
  parameter int START_STATE  = 0,
  parameter int GOAL_STATE   = 15,
  parameter int MAX_STEPS    = 64,
  parameter int NUM_EPISODES = 300,
  parameter int EPS_STEP     = 217
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [3:0]  q_rd_addr,
  input  logic [63:0] q_rd_data,
  output logic [63:0] q_values,
  output logic [15:0] epsilon,
  output logic        sel_start,
  input  logic [3:0]  action,
  output logic        upd_valid,
  input  logic        upd_ready,
  output logic [3:0]  upd_state,
  output logic [3:0]  upd_action,
  output logic [3:0]  upd_next_state,
  output logic [15:0] upd_reward,
  output logic [3:0]  state,
  output logic [6:0]  step,
  output logic [8:0]  episode,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0]  START_S     = 4'(START_STATE);
  localparam logic [3:0]  GOAL_S      = 4'(GOAL_STATE);
  localparam logic [3:0]  GRID_S      = 4'(GRID_W);
  localparam logic [3:0]  EDGE_IDX    = 4'(GRID_W - 1);
  localparam logic [6:0]  LAST_STEP   = 7'(MAX_STEPS - 1);
  localparam logic [8:0]  LAST_EP     = 9'(NUM_EPISODES - 1);
  localparam logic [15:0] EPS_DEC     = 16'(EPS_STEP);
  localparam logic [15:0] EPS_FULL    = 16'hFFFF;
  localparam logic [15:0] REWARD_WALL = 16'(-10);
  localparam logic [15:0] REWARD_STEP = 16'(-1);
  localparam logic [15:0] REWARD_GOAL = 16'(100);
  localparam int          Q_LANES     = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_SELECT, S_MOVE, S_UPDATE, S_EP_END, S_DONE
  } fsm_t;

  fsm_t        fsm_reg, fsm_next;
  logic [3:0]  state_reg, state_next;
  logic [6:0]  step_reg, step_next;
  logic [8:0]  episode_reg, episode_next;
  logic [15:0] epsilon_reg, epsilon_next;
  logic        sel_start_reg, sel_start_next;
  logic [3:0]  upd_state_reg, upd_state_next;
  logic [3:0]  upd_action_reg, upd_action_next;
  logic [3:0]  upd_next_state_reg, upd_next_state_next;
  logic [15:0] upd_reward_reg, upd_reward_next;
  logic [63:0] q_values_reg;

  logic [3:0]  cur_row, cur_col;
  logic [3:0]  move_next;
  logic [15:0] move_reward;
  logic        move_legal;

  // Move evaluation: decode the chosen action against the current cell;
  // anything that would leave the grid (or an unknown action) stays put.
  always_comb begin
    cur_row     = state_reg / GRID_S;
    cur_col     = state_reg % GRID_S;
    move_legal  = 1'b0;
    move_next   = state_reg;
    move_reward = REWARD_WALL;
    case (upd_action_reg)
      4'd1: if (cur_row != 4'd0) begin
        move_legal = 1'b1;
        move_next  = state_reg - GRID_S;
      end
      4'd2: if (cur_row != EDGE_IDX) begin
        move_legal = 1'b1;
        move_next  = state_reg + GRID_S;
      end
      4'd3: if (cur_col != 4'd0) begin
        move_legal = 1'b1;
        move_next  = state_reg - 4'd1;
      end
      4'd4: if (cur_col != EDGE_IDX) begin
        move_legal = 1'b1;
        move_next  = state_reg + 4'd1;
      end
      default: ;
    endcase
    if (move_legal) begin
      move_reward = (move_next == GOAL_S) ? REWARD_GOAL : REWARD_STEP;
    end
  end

  // Next-state and datapath decisions for the episode sequencer.
  always_comb begin
    fsm_next            = fsm_reg;
    state_next          = state_reg;
    step_next           = step_reg;
    episode_next        = episode_reg;
    epsilon_next        = epsilon_reg;
    sel_start_next      = 1'b0;
    upd_state_next      = upd_state_reg;
    upd_action_next     = upd_action_reg;
    upd_next_state_next = upd_next_state_reg;
    upd_reward_next     = upd_reward_reg;
    case (fsm_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          step_next      = 7'd0;
          episode_next   = 9'd0;
          state_next     = START_S;
          epsilon_next   = EPS_FULL;
          sel_start_next = 1'b1;
          fsm_next       = S_READ;
        end
      end
      S_READ:   fsm_next = S_WAIT;
      S_WAIT:   fsm_next = S_SELECT;
      S_SELECT: begin
        upd_action_next = action;
        fsm_next        = S_MOVE;
      end
      S_MOVE: begin
        upd_state_next      = state_reg;
        upd_next_state_next = move_next;
        upd_reward_next     = move_reward;
        fsm_next            = S_UPDATE;
      end
      S_UPDATE: begin
        if (upd_ready) begin
          if (upd_next_state_reg == GOAL_S || step_reg == LAST_STEP) begin
            fsm_next = S_EP_END;
          end else begin
            state_next = upd_next_state_reg;
            step_next  = step_reg + 7'd1;
            fsm_next   = S_READ;
          end
        end
      end
      S_EP_END: begin
        if (episode_reg == LAST_EP) begin
          fsm_next = S_DONE;
        end else begin
          // Stepping down by a fixed amount each episode is the same as
          // full-scale minus episode*EPS_STEP modulo 2^16.
          episode_next = episode_reg + 9'd1;
          epsilon_next = epsilon_reg - EPS_DEC;
          state_next   = START_S;
          step_next    = 7'd0;
          fsm_next     = S_READ;
        end
      end
      default: fsm_next = S_IDLE;
    endcase
  end

  // Control and payload registers; reset returns to an idle, full-exploration state.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg            <= S_IDLE;
      state_reg          <= START_S;
      step_reg           <= 7'd0;
      episode_reg        <= 9'd0;
      epsilon_reg        <= EPS_FULL;
      sel_start_reg      <= 1'b0;
      upd_state_reg      <= 4'd0;
      upd_action_reg     <= 4'd0;
      upd_next_state_reg <= 4'd0;
      upd_reward_reg     <= 16'd0;
    end else begin
      fsm_reg            <= fsm_next;
      state_reg          <= state_next;
      step_reg           <= step_next;
      episode_reg        <= episode_next;
      epsilon_reg        <= epsilon_next;
      sel_start_reg      <= sel_start_next;
      upd_state_reg      <= upd_state_next;
      upd_action_reg     <= upd_action_next;
      upd_next_state_reg <= upd_next_state_next;
      upd_reward_reg     <= upd_reward_next;
    end
  end

  // Q row capture, one 16-bit action value per lane, taken while the
  // memory's registered read data is valid.
  generate
    for (genvar gi = 0; gi < Q_LANES; gi++) begin : g_q_lane
      always_ff @(posedge clk) begin
        if (rst) begin
          q_values_reg[gi*16 +: 16] <= 16'd0;
        end else if (fsm_reg == S_WAIT) begin
          q_values_reg[gi*16 +: 16] <= q_rd_data[gi*16 +: 16];
        end
      end
    end
  endgenerate

  // The address is only presented during READ so the memory sees one access per step.
  assign q_rd_addr      = (fsm_reg == S_READ) ? state_reg : 4'd0;
  assign q_values       = q_values_reg;
  assign epsilon        = epsilon_reg;
  assign sel_start      = sel_start_reg;
  assign upd_valid      = (fsm_reg == S_UPDATE);
  assign upd_state      = upd_state_reg;
  assign upd_action     = upd_action_reg;
  assign upd_next_state = upd_next_state_reg;
  assign upd_reward     = upd_reward_reg;
  assign state          = state_reg;
  assign step           = step_reg;
  assign episode        = episode_reg;
  assign busy           = (fsm_reg != S_IDLE) && (fsm_reg != S_DONE);
  assign done           = (fsm_reg == S_DONE);

endmodule

// File: tb/tb_maze_episode_controller.sv
// Bench for maze_episode_controller: a step-timeline reference model is
// advanced on every rising edge and compared against the DUT every cycle,
// with directed scenarios pinned by hand-computed literals and a randomized run.
module tb_maze_episode_controller;

  localparam int GRID_W       = 4;
  localparam int START_STATE  = 0;
  localparam int GOAL_STATE   = 15;
  localparam int MAX_STEPS    = 64;
  localparam int NUM_EPISODES = 2;
  localparam int EPS_STEP     = 217;

  localparam int MODE_IDLE = 0;
  localparam int MODE_RUN  = 1;
  localparam int MODE_DONE = 2;

  logic        clk = 1'b0;
  logic        rst, start, upd_ready;
  logic [3:0]  action;
  logic [63:0] q_rd_data;
  logic [3:0]  q_rd_addr, upd_state, upd_action, upd_next_state, state;
  logic [63:0] q_values;
  logic [15:0] epsilon, upd_reward;
  logic        sel_start, upd_valid, busy, done;
  logic [6:0]  step;
  logic [8:0]  episode;

  always #5 clk = ~clk;

  maze_episode_controller #(
    .GRID_W(GRID_W), .START_STATE(START_STATE), .GOAL_STATE(GOAL_STATE),
    .MAX_STEPS(MAX_STEPS), .NUM_EPISODES(NUM_EPISODES), .EPS_STEP(EPS_STEP)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .q_rd_addr(q_rd_addr), .q_rd_data(q_rd_data), .q_values(q_values),
    .epsilon(epsilon), .sel_start(sel_start), .action(action),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_state(upd_state), .upd_action(upd_action),
    .upd_next_state(upd_next_state), .upd_reward(upd_reward),
    .state(state), .step(step), .episode(episode), .busy(busy), .done(done)
  );

  // Q-table memory with a one-cycle registered read.
  logic [63:0] qtab [16];
  always @(posedge clk) q_rd_data <= qtab[q_rd_addr];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: position within a step (0..4 = the five cycles of a
  // step, 5 = the episode wrap-up cycle) plus the agent's position.
  int          cyc = 0;
  int          m_mode = MODE_IDLE, m_phase = 0;
  int          m_state = START_STATE, m_step = 0, m_ep = 0;
  int          m_act = 0, m_next = 0, m_rew = 0;
  logic [63:0] m_qv = 64'd0;
  bit          m_sel = 1'b0;

  // Observed transfers.
  int          n_xfer = 0;
  int          xfer_cyc = 0;
  logic [3:0]  cap_state, cap_next;
  logic [15:0] cap_reward;

  function automatic void predict(input int s, input int a, output int nx, output int rw);
    int r  = s / GRID_W;
    int c  = s % GRID_W;
    int nr = r;
    int nc = c;
    bit legal = 1'b1;
    case (a)
      1: nr = r - 1;
      2: nr = r + 1;
      3: nc = c - 1;
      4: nc = c + 1;
      default: legal = 1'b0;
    endcase
    if (nr < 0 || nr >= GRID_W || nc < 0 || nc >= GRID_W) legal = 1'b0;
    if (!legal) begin
      nx = s;
      rw = -10;
    end else begin
      nx = nr * GRID_W + nc;
      rw = (nx == GOAL_STATE) ? 100 : -1;
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired, required event not observed (cycle %0d)", name, cyc);
  endtask

  task automatic model_step();
    cyc++;
    if (rst) begin
      m_mode = MODE_IDLE; m_phase = 0; m_state = START_STATE;
      m_step = 0; m_ep = 0; m_sel = 1'b0; m_qv = 64'd0;
    end else begin
      m_sel = 1'b0;
      if (m_mode != MODE_RUN) begin
        if (start) begin
          m_mode = MODE_RUN; m_phase = 0; m_state = START_STATE;
          m_step = 0; m_ep = 0; m_sel = 1'b1;
        end
      end else begin
        case (m_phase)
          0: m_phase = 1;
          1: begin m_qv = qtab[m_state]; m_phase = 2; end
          2: begin m_act = int'(action); predict(m_state, m_act, m_next, m_rew); m_phase = 3; end
          3: m_phase = 4;
          4: if (upd_ready) begin
               if (m_next == GOAL_STATE || m_step == MAX_STEPS - 1) m_phase = 5;
               else begin m_state = m_next; m_step++; m_phase = 0; end
             end
          default: begin
            if (m_ep == NUM_EPISODES - 1) m_mode = MODE_DONE;
            else begin m_ep++; m_state = START_STATE; m_step = 0; m_phase = 0; end
          end
        endcase
      end
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  task automatic compare_cycle();
    bit          e_run   = (m_mode == MODE_RUN);
    bit          e_valid = e_run && (m_phase == 4);
    logic [15:0] e_eps   = 16'(65535 - m_ep * EPS_STEP);
    logic [15:0] e_rew   = 16'(m_rew);
    logic [3:0]  e_addr  = (e_run && m_phase == 0) ? 4'(m_state) : 4'd0;
    chk("busy",      64'(busy),      64'(e_run));
    chk("done",      64'(done),      64'(m_mode == MODE_DONE));
    chk("upd_valid", 64'(upd_valid), 64'(e_valid));
    chk("state",     64'(state),     64'(m_state));
    chk("step",      64'(step),      64'(m_step));
    chk("episode",   64'(episode),   64'(m_ep));
    chk("epsilon",   64'(epsilon),   64'(e_eps));
    chk("sel_start", 64'(sel_start), 64'(m_sel));
    chk("q_rd_addr", 64'(q_rd_addr), 64'(e_addr));
    chk("q_values",  q_values,       m_qv);
    if (e_valid) begin
      chk("upd_state",      64'(upd_state),      64'(m_state));
      chk("upd_action",     64'(upd_action),     64'(m_act));
      chk("upd_next_state", 64'(upd_next_state), 64'(m_next));
      chk("upd_reward",     64'(upd_reward),     64'(e_rew));
    end
  endtask

  // One clock: note a handshake and advance the model on the rising edge
  // (pre-edge values), then compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst && upd_valid && upd_ready) begin
      n_xfer++;
      xfer_cyc   = cyc;
      cap_state  = upd_state;
      cap_next   = upd_next_state;
      cap_reward = upd_reward;
      $display("[TB] xfer %0d: ep=%0d step=%0d state=%0d action=%0d next=%0d reward=%0d",
               n_xfer, episode, step, upd_state, upd_action, upd_next_state,
               $signed(upd_reward));
    end
    model_step();
    @(negedge clk);
    compare_cycle();
  endtask

  task automatic wait_xfer(input int target, input string name);
    int k = 0;
    while (n_xfer < target && k < 500) begin tick(); k++; end
    if (n_xfer < target) note_timeout(name);
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!upd_valid && k < 50) begin tick(); k++; end
    if (!upd_valid) note_timeout(name);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int base, t_prev, ep_base, k;
    for (int i = 0; i < 16; i++) qtab[i] = {$urandom, $urandom};
    rst = 1'b1; start = 1'b0; upd_ready = 1'b1; action = 4'd0;

    // Reset held for two cycles.
    tick(); tick();
    chk("rst_upd_valid", 64'(upd_valid), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_done",      64'(done),      64'd0);
    chk("rst_epsilon",   64'(epsilon),   64'hFFFF);
    chk("rst_state",     64'(state),     64'd0);
    chk("rst_episode",   64'(episode),   64'd0);

    // Reset wins over a simultaneous start.
    start = 1'b1; tick();
    rst = 1'b0; start = 1'b0; tick();
    chk("rst_over_start_busy", 64'(busy), 64'd0);

    // Wall bump from the start cell, then reset in the middle of a handshake.
    action = 4'd1;
    pulse_start();
    chk("start_sel_start", 64'(sel_start), 64'd1);
    wait_xfer(1, "wall_xfer");
    chk("wall_state",  64'(cap_state),  64'd0);
    chk("wall_next",   64'(cap_next),   64'd0);
    chk("wall_reward", 64'(cap_reward), 64'hFFF6);
    chk("wall_step",   64'(step),       64'd1);
    upd_ready = 1'b0;
    wait_valid("mid_handshake_valid");
    rst = 1'b1; tick();
    chk("midrst_upd_valid", 64'(upd_valid), 64'd0);
    chk("midrst_busy",      64'(busy),      64'd0);
    chk("midrst_step",      64'(step),      64'd0);
    rst = 1'b0; upd_ready = 1'b1; tick();

    // Directed path 4,4,4,2,2,2 to the goal, with backpressure on step 3.
    base = n_xfer;
    action = 4'd4;
    pulse_start();
    wait_xfer(base + 1, "goal_xfer1");
    chk("first_state",  64'(cap_state),  64'd0);
    chk("first_next",   64'(cap_next),   64'd1);
    chk("first_reward", 64'(cap_reward), 64'hFFFF);
    t_prev = xfer_cyc;
    wait_xfer(base + 2, "goal_xfer2");
    chk("step_period", 64'(xfer_cyc - t_prev), 64'd5);
    chk("second_next", 64'(cap_next), 64'd2);
    t_prev = xfer_cyc;
    upd_ready = 1'b0;
    wait_valid("stall_valid_wait");
    tick(); tick(); tick();
    chk("stall_upd_valid", 64'(upd_valid), 64'd1);
    chk("stall_state",     64'(state),     64'd2);
    chk("stall_step",      64'(step),      64'd2);
    upd_ready = 1'b1;
    wait_xfer(base + 3, "goal_xfer3");
    chk("stall_period", 64'(xfer_cyc - t_prev), 64'd8);
    chk("third_next",   64'(cap_next), 64'd3);
    action = 4'd2;
    wait_xfer(base + 4, "goal_xfer4");
    chk("fourth_next", 64'(cap_next), 64'd7);
    wait_xfer(base + 5, "goal_xfer5");
    chk("fifth_next", 64'(cap_next), 64'd11);
    wait_xfer(base + 6, "goal_xfer6");
    chk("goal_next",   64'(cap_next),   64'd15);
    chk("goal_reward", 64'(cap_reward), 64'd100);
    tick();
    chk("ep1_episode", 64'(episode), 64'd1);
    chk("ep1_epsilon", 64'(epsilon), 64'd65318);
    chk("ep1_state",   64'(state),   64'd0);
    chk("ep1_step",    64'(step),    64'd0);

    // Final episode bumping the top wall until the step limit ends the run.
    action  = 4'd1;
    ep_base = n_xfer;
    k = 0;
    while (!done && k < 2000) begin
      upd_ready = ($urandom_range(0, 3) != 0);
      tick(); k++;
    end
    if (!done) note_timeout("run_end_done");
    upd_ready = 1'b1;
    chk("run_end_xfers",   64'(n_xfer - ep_base), 64'd64);
    chk("run_end_done",    64'(done),    64'd1);
    chk("run_end_busy",    64'(busy),    64'd0);
    chk("run_end_episode", 64'(episode), 64'd1);
    chk("run_end_step",    64'(step),    64'd63);
    tick(); tick();
    chk("done_hold_step", 64'(step), 64'd63);

    // Restart from DONE, then a randomized run to completion.
    pulse_start();
    chk("restart_episode", 64'(episode), 64'd0);
    chk("restart_busy",    64'(busy),    64'd1);
    chk("restart_epsilon", 64'(epsilon), 64'hFFFF);
    k = 0;
    while (!done && k < 3000) begin
      action    = 4'($urandom_range(0, 6));
      upd_ready = ($urandom_range(0, 3) != 0);
      start     = busy && ($urandom_range(0, 15) == 0);
      tick(); k++;
    end
    start = 1'b0;
    if (!done) note_timeout("random_run_done");
    chk("random_done_busy", 64'(busy), 64'd0);

    // Closing reset.
    rst = 1'b1; tick(); tick();
    rst = 1'b0; tick();
    chk("final_done",    64'(done),    64'd0);
    chk("final_epsilon", 64'(epsilon), 64'hFFFF);
    chk("final_episode", 64'(episode), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/maze_episode_controller.md
MAZE_EPISODE_CONTROLLER -- requirements
Module: maze_episode_controller

Interface
REQ-001 Parameters (name, default, meaning): GRID_W, 4, maze side length; state = row*GRID_W + col, 16 states.
REQ-002 Parameters: START_STATE, 0, episode start cell; GOAL_STATE, 15, terminal cell.
REQ-003 Parameters: MAX_STEPS, 64, step limit per episode; NUM_EPISODES, 300, episodes per run; EPS_STEP, 217, epsilon decrement per episode.
REQ-004 Ports (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
REQ-005 start in 1: one-cycle request to begin a training run.
REQ-006 q_rd_addr out 4: Q-table row address; q_rd_data in 64: row data, valid exactly 1 cycle after the address is presented.
REQ-007 q_values out 64: Q row forwarded to the action selector; epsilon out 16: exploration threshold; sel_start out 1: randomizer start pulse; action in 4: selector result (1=up, 2=down, 3=left, 4=right).
REQ-008 upd_valid out 1, upd_ready in 1: update handshake; payload upd_state out 4, upd_action out 4, upd_next_state out 4, upd_reward out 16 (signed).
REQ-009 Status outputs: state out 4, step out 7, episode out 9, busy out 1, done out 1.

Function
REQ-010 FSM states: IDLE, READ, WAIT, SELECT, MOVE, UPDATE, EP_END, DONE.
REQ-011 IDLE or DONE with start=1: clear step and episode, set state=START_STATE and epsilon=16'hFFFF, pulse sel_start for 1 cycle, go to READ; start is ignored in all other states.
REQ-012 READ: drive q_rd_addr=state for 1 cycle, then go to WAIT.
REQ-013 WAIT: register q_rd_data into q_values, then go to SELECT.
REQ-014 SELECT: register action into upd_action, then go to MOVE.
REQ-015 MOVE: compute next state and reward (REQ-016 to REQ-018), then go to UPDATE.
REQ-016 Moves: up = row-1, down = row+1, left = col-1, right = col+1; a move leaving the grid keeps the same state and gives reward -10.
REQ-017 Action 0 or >4 keeps the same state and gives reward -10.
REQ-018 Legal move reaching GOAL_STATE gives reward +100; any other legal move gives reward -1.
REQ-019 UPDATE: assert upd_valid with upd_state=state; payload stays stable while upd_valid=1 and upd_ready=0.
REQ-020 Transfer occurs on a cycle with upd_valid and upd_ready both high; upd_valid deasserts the following cycle.
REQ-021 After transfer, if next==GOAL_STATE or step==MAX_STEPS-1, go to EP_END; otherwise state<=next, step<=step+1, go to READ.
REQ-022 EP_END: if episode==NUM_EPISODES-1, go to DONE; otherwise episode<=episode+1, epsilon<=16'hFFFF - (episode+1)*EPS_STEP (16-bit unsigned, no wrap for the defaults), state<=START_STATE, step<=0, go to READ.
REQ-023 busy=1 in every state except IDLE and DONE; done=1 only in DONE; in DONE, state/step/episode hold their final values.
REQ-024 With upd_ready held high, one step takes exactly 5 cycles (READ through UPDATE); EP_END adds 1 cycle.

Reset
REQ-025 rst=1 at any clock edge, including mid-handshake, forces IDLE.
REQ-026 On reset, all outputs are 0 except epsilon=16'hFFFF and state=START_STATE; upd_valid drops on that edge.
REQ-027 rst has priority over start in the same cycle.

Verification
REQ-028 Reset: assert rst for 2 cycles -> upd_valid=0, busy=0, done=0, epsilon=16'hFFFF, state=0, episode=0.
REQ-029 Step timing: start, action=4, upd_ready=1 -> first transfer has upd_state=0, upd_next_state=1, upd_reward=-1; the next transfer follows 5 cycles later.
REQ-030 Wall bump: state 0, action=1 -> upd_next_state=0, upd_reward=-10, step increments to 1.
REQ-031 Goal: action sequence 4,4,4,2,2,2 -> 6th transfer has upd_next_state=15, upd_reward=100; then episode=1, epsilon=65318, state=0, step=0.
REQ-032 Backpressure: upd_ready=0 for 3 cycles during UPDATE -> upd_valid stays high with a stable payload, and state/step do not change until the transfer.
REQ-033 Run end: NUM_EPISODES=2, action always 1 -> 64 transfers per episode, then done=1, busy=0, episode=1; a later start restarts from episode 0.
